instruction_memory_responder: RTL and testbench

Memory-side responder for the core's instruction fetch interface. It takes the core's byte-address program counter and returns the addressed 32-bit instruction word on the core's memory input one cycle later. Before the core runs, it accepts a little-endian byte stream over a valid/ready port and writes it into its word array. It sits between the top-level program source and the core, and holds the core idle until loading completes.

---
 rtl/instruction_memory_responder_pkg.sv | 21 ++
 rtl/instruction_memory_responder_if.sv | 34 +++
 rtl/instruction_memory_responder_ram.sv | 34 +++
 rtl/instruction_memory_responder.sv | 123 ++++++++++++
 tb/tb_instruction_memory_responder.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/instruction_memory_responder_pkg.sv
// Shared types and constants for the instruction memory responder.
// Holds the data width, state encodings and the word-completion helper.
package instruction_memory_responder_pkg;

  localparam int IMR_DATA_WIDTH = 32;
  localparam int IMR_BYTES_PER_WORD = 4;

  typedef enum logic {
    IMR_LOAD = 1'b0,
    IMR_RUN  = 1'b1
  } imr_state_e;

  // A word is written on its 4th byte or on the final byte of the program.
  function automatic logic word_complete(
    input logic [1:0] cnt,
    input logic       last
  );
    word_complete = (cnt == 2'd3) || last;
  endfunction

endpackage

// File: rtl/instruction_memory_responder_if.sv
// Program-load handshake plus fetch address/data bundle.
// master: program source and core side; slave: the responder.
interface instruction_memory_responder_if
  import instruction_memory_responder_pkg::*;
#(
  parameter int DATA_WIDTH = IMR_DATA_WIDTH
);

  logic [DATA_WIDTH-1:0] pc_in;
  logic [DATA_WIDTH-1:0] mem_out;
  logic                  load_valid;
  logic [7:0]            load_byte;
  logic                  load_last;
  logic                  load_ready;

  modport master (
    output pc_in,
    output load_valid,
    output load_byte,
    output load_last,
    input  mem_out,
    input  load_ready
  );

  modport slave (
    input  pc_in,
    input  load_valid,
    input  load_byte,
    input  load_last,
    output mem_out,
    output load_ready
  );

endinterface

// File: rtl/instruction_memory_responder_ram.sv
// instruction_ram: one write port, one registered read port with enable.
// Ports: clk, wr_en/wr_addr/wr_data, rd_en/rd_addr, rd_data (registered).
module instruction_ram
  import instruction_memory_responder_pkg::*;
#(
  parameter int DATA_WIDTH  = IMR_DATA_WIDTH,
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_BITS   = $clog2(DEPTH_WORDS)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_BITS-1:0]  wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_BITS-1:0]  rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];
  logic [DATA_WIDTH-1:0] rd_data_q;

  // No reset on storage or read register so this maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_q <= mem_q[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/instruction_memory_responder.sv
// Loads a little-endian byte stream into instruction RAM, then serves fetches.
// Ports: clk, reset (sync, active-low), bus (load + fetch), core_run, words_loaded, addr_err.
module instruction_memory_responder
  import instruction_memory_responder_pkg::*;
#(
  parameter int DATA_WIDTH  = IMR_DATA_WIDTH,
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_BITS   = $clog2(DEPTH_WORDS)
) (
  input  logic                         clk,
  input  logic                         reset,
  instruction_memory_responder_if.slave bus,
  output logic                         core_run,
  output logic [ADDR_BITS:0]           words_loaded,
  output logic                         addr_err
);

  localparam logic [ADDR_BITS-1:0] PTR_ONE  = {{(ADDR_BITS-1){1'b0}}, 1'b1};
  localparam logic [ADDR_BITS:0]   WORD_ONE = {{ADDR_BITS{1'b0}}, 1'b1};

  imr_state_e            state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] asm_q, asm_d;
  logic [ADDR_BITS-1:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR_BITS:0]    words_q, words_d;
  logic                  err_q, err_d;
  logic                  zero_q, zero_d;

  logic                  accept;
  logic                  wr_en;
  logic                  rd_en;
  logic                  oob;
  logic                  misaligned;
  logic [DATA_WIDTH-1:0] wr_word;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [ADDR_BITS-1:0]  rd_idx;

  assign core_run       = (state_q == IMR_RUN);
  assign bus.load_ready = (state_q == IMR_LOAD);
  assign words_loaded   = words_q;
  assign addr_err       = err_q;

  // Gating with reset keeps a byte presented during reset out of the RAM.
  assign accept = bus.load_valid && bus.load_ready && reset;

  // Lanes above the current byte are still zero in asm_q, so a short
  // final word is written with its upper lanes cleared.
  assign wr_word = asm_q
                 | (DATA_WIDTH'(bus.load_byte) << {cnt_q, 3'b000});
  assign wr_en   = accept && word_complete(cnt_q, bus.load_last);

  assign rd_idx     = bus.pc_in[ADDR_BITS+1:2];
  assign oob        = |bus.pc_in[DATA_WIDTH-1:ADDR_BITS+2];
  assign misaligned = |bus.pc_in[1:0];
  assign rd_en      = core_run;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    asm_d    = asm_q;
    wr_ptr_d = wr_ptr_q;
    words_d  = words_q;
    err_d    = err_q;
    zero_d   = zero_q;
    if (accept) begin
      if (wr_en) begin
        cnt_d    = 2'd0;
        asm_d    = '0;
        wr_ptr_d = wr_ptr_q + PTR_ONE;
        words_d  = words_q + WORD_ONE;
        // Filling the last slot ends the load even without load_last.
        if (bus.load_last || (&wr_ptr_q)) begin
          state_d = IMR_RUN;
        end
      end else begin
        cnt_d = cnt_q + 2'd1;
        asm_d = wr_word;
      end
    end
    if (core_run) begin
      err_d  = err_q | oob | misaligned;
      zero_d = oob;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IMR_LOAD;
      cnt_q    <= 2'd0;
      asm_q    <= '0;
      wr_ptr_q <= '0;
      words_q  <= '0;
      err_q    <= 1'b0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      asm_q    <= asm_d;
      wr_ptr_q <= wr_ptr_d;
      words_q  <= words_d;
      err_q    <= err_d;
      zero_q   <= zero_d;
    end
  end

  instruction_ram #(
    .DATA_WIDTH  (DATA_WIDTH),
    .DEPTH_WORDS (DEPTH_WORDS),
    .ADDR_BITS   (ADDR_BITS)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_q),
    .wr_data (wr_word),
    .rd_en   (rd_en),
    .rd_addr (rd_idx),
    .rd_data (rd_word)
  );

  // zero_q masks the RAM output in LOAD and after an out-of-range fetch.
  assign bus.mem_out = zero_q ? '0 : rd_word;

endmodule

// File: tb/tb_instruction_memory_responder.sv
// Self-checking bench: two responders (1024 and 4 words) share one stimulus
// stream; each is compared every cycle against a queue-based program model.
module tb_instruction_memory_responder;

  logic        clk;
  logic        reset;
  logic [31:0] pc_in;
  logic        load_valid;
  logic [7:0]  load_byte;
  logic        load_last;
  bit          cmp_en;
  int          checks;
  int          errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int D  = (g == 0) ? 1024 : 4;
    localparam int AB = $clog2(D);

    instruction_memory_responder_if bus ();
    logic          core_run;
    logic [AB:0]   words_loaded;
    logic          addr_err;

    assign bus.pc_in      = pc_in;
    assign bus.load_valid = load_valid;
    assign bus.load_byte  = load_byte;
    assign bus.load_last  = load_last;

    instruction_memory_responder #(
      .DEPTH_WORDS (D)
    ) u_dut (
      .clk          (clk),
      .reset        (reset),
      .bus          (bus),
      .core_run     (core_run),
      .words_loaded (words_loaded),
      .addr_err     (addr_err)
    );

    bit          m_run;
    bit          m_err;
    int          m_words;
    logic [31:0] m_out;
    bit          m_known;
    logic [7:0]  part[$];
    logic [31:0] m_mem[D];
    bit          m_valid[D];

    always @(posedge clk) begin
      logic [31:0] w;
      int          idx;
      if (!reset) begin
        m_run   = 0;
        m_err   = 0;
        m_words = 0;
        m_out   = 0;
        m_known = 1;
        part.delete();
      end else if (!m_run) begin
        if (load_valid) begin
          part.push_back(load_byte);
          if (part.size() == 4 || load_last) begin
            w = 0;
            for (int i = 0; i < part.size(); i++) w[8*i +: 8] = part[i];
            m_mem[m_words]   = w;
            m_valid[m_words] = 1;
            m_words++;
            part.delete();
            if (load_last || m_words == D) m_run = 1;
          end
        end
      end else begin
        if (pc_in >= 32'(4 * D)) begin
          m_out   = 0;
          m_known = 1;
          m_err   = 1;
        end else begin
          idx     = int'(pc_in / 4);
          m_out   = m_mem[idx];
          m_known = m_valid[idx];
          if (pc_in % 4 != 0) m_err = 1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_dut(input string tag, input logic [31:0] words,
                         input logic run, input logic ready,
                         input logic err, input logic [31:0] out,
                         input int m_words, input bit m_run,
                         input bit m_err, input logic [31:0] m_out,
                         input bit m_known);
    chk({tag, "_words"}, words, m_words);
    chk({tag, "_core_run"}, 32'(run), 32'(m_run));
    chk({tag, "_load_ready"}, 32'(ready), 32'(!m_run));
    chk({tag, "_addr_err"}, 32'(err), 32'(m_err));
    if (m_known) chk({tag, "_mem_out"}, out, m_out);
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      cmp_dut("big", 32'(g_inst[0].words_loaded), g_inst[0].core_run,
              g_inst[0].bus.load_ready, g_inst[0].addr_err,
              g_inst[0].bus.mem_out, g_inst[0].m_words, g_inst[0].m_run,
              g_inst[0].m_err, g_inst[0].m_out, g_inst[0].m_known);
      cmp_dut("small", 32'(g_inst[1].words_loaded), g_inst[1].core_run,
              g_inst[1].bus.load_ready, g_inst[1].addr_err,
              g_inst[1].bus.mem_out, g_inst[1].m_words, g_inst[1].m_run,
              g_inst[1].m_err, g_inst[1].m_out, g_inst[1].m_known);
    end
  end

  task automatic do_reset();
    reset      = 1'b0;
    load_valid = 1'b0;
    load_last  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    cmp_en = 1;
    chk("rst_words", 32'(g_inst[0].words_loaded), 32'd0);
    chk("rst_core_run", 32'(g_inst[0].core_run), 32'd0);
    chk("rst_load_ready", 32'(g_inst[0].bus.load_ready), 32'd1);
    chk("rst_mem_out", g_inst[0].bus.mem_out, 32'd0);
    chk("rst_addr_err", 32'(g_inst[1].addr_err), 32'd0);
    reset = 1'b1;
  endtask

  task automatic send(input logic [7:0] b, input logic last);
    load_valid = 1'b1;
    load_byte  = b;
    load_last  = last;
    @(negedge clk);
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a);
    pc_in = a;
    @(negedge clk);
  endtask

  logic [7:0]  basic[8] = '{8'h13, 8'h00, 8'h00, 8'h00,
                            8'h93, 8'h00, 8'h10, 8'h00};
  logic [7:0]  fb[16];
  logic [31:0] w0;
  logic [31:0] pc;
  int          n;
  bit          with_last;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset      = 1'b0;
    pc_in      = '0;
    load_valid = 1'b0;
    load_byte  = '0;
    load_last  = 1'b0;
    cmp_en     = 0;
    checks     = 0;
    errors     = 0;
    @(negedge clk);

    do_reset();
    for (int i = 0; i < 8; i++) send(basic[i], i == 7);
    chk("basic_words", 32'(g_inst[0].words_loaded), 32'd2);
    chk("basic_core_run", 32'(g_inst[0].core_run), 32'd1);
    fetch(32'h0);
    chk("basic_word0", g_inst[0].bus.mem_out, 32'h0000_0013);
    fetch(32'h4);
    chk("basic_word1", g_inst[0].bus.mem_out, 32'h0010_0093);
    for (int i = 0; i < 3; i++) send(8'($urandom), 1'b0);
    chk("post_ready", 32'(g_inst[0].bus.load_ready), 32'd0);
    chk("post_words", 32'(g_inst[0].words_loaded), 32'd2);
    fetch(32'h4);
    chk("post_word1", g_inst[0].bus.mem_out, 32'h0010_0093);

    do_reset();
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b0);
    send(8'hCC, 1'b1);
    chk("partial_words", 32'(g_inst[0].words_loaded), 32'd1);
    fetch(32'h0);
    chk("partial_word0", g_inst[0].bus.mem_out, 32'h00CC_BBAA);

    do_reset();
    for (int i = 0; i < 8; i++) begin
      load_byte = 8'($urandom);
      load_last = 1'($urandom_range(0, 1));
      @(negedge clk);
      send(basic[i], i == 7);
    end
    chk("gap_words", 32'(g_inst[0].words_loaded), 32'd2);
    fetch(32'h0);
    chk("gap_word0", g_inst[0].bus.mem_out, 32'h0000_0013);
    fetch(32'h4);
    chk("gap_word1", g_inst[0].bus.mem_out, 32'h0010_0093);

    do_reset();
    for (int i = 0; i < 16; i++) fb[i] = 8'($urandom);
    for (int i = 0; i < 16; i++) send(fb[i], 1'b0);
    chk("full_core_run", 32'(g_inst[1].core_run), 32'd1);
    chk("full_words", 32'(g_inst[1].words_loaded), 32'd4);
    send(8'h5A, 1'b0);
    chk("full_17th_words", 32'(g_inst[1].words_loaded), 32'd4);
    w0 = {fb[3], fb[2], fb[1], fb[0]};
    fetch(32'h2);
    chk("misalign_out", g_inst[1].bus.mem_out, w0);
    chk("misalign_err", 32'(g_inst[1].addr_err), 32'd1);
    fetch(32'h10);
    chk("oob_out", g_inst[1].bus.mem_out, 32'd0);
    chk("oob_err", 32'(g_inst[1].addr_err), 32'd1);
    fetch(32'h0);
    chk("sticky_err", 32'(g_inst[1].addr_err), 32'd1);

    do_reset();
    for (int i = 0; i < 5; i++) send(8'($urandom), 1'b0);
    do_reset();
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    send(8'h44, 1'b1);
    fetch(32'h0);
    chk("reload_word0", g_inst[0].bus.mem_out, 32'h4433_2211);

    for (int it = 0; it < 30; it++) begin
      do_reset();
      n         = $urandom_range(1, 24);
      with_last = 1'($urandom_range(0, 1));
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 2) == 0) begin
          load_byte = 8'($urandom);
          load_last = 1'($urandom_range(0, 1));
          @(negedge clk);
        end
        send(8'($urandom), with_last && (i == n - 1));
      end
      repeat (20) begin
        case ($urandom_range(0, 3))
          0, 1:    pc = 32'($urandom_range(0, 15)) * 4;
          2:       pc = 32'($urandom_range(0, 63));
          default: pc = $urandom;
        endcase
        fetch(pc);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
